// File: rtl/mem_arb_pkg.sv
// Types shared by the memory request arbiter and its bench.
// Latency: none (types only).
// Backpressure: not applicable.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_DRAIN
    } arb_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester above ptr_i (with wrap) wins.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          vld_o
);

    logic [PW-1:0] cand;
    logic          found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        found = 1'b0;
        // i = N revisits ptr_i itself last, so the previous winner ranks lowest.
        for (int i = 1; i <= N; i++) begin
            cand = PW'((int'(ptr_i) + i) % N);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
        vld_o = found;
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one req/rvalid memory port between NUM_REQ requesters, one transaction in flight.
// Latency: grant same cycle as request, mem_req_o next cycle, response routed with zero added latency.
// Backpressure: requesters hold req_i until gnt_o; a hung memory is cut off by the response timeout.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          NUM_REQ     = 2,
    parameter logic [31:0] ADDR_OFFSET = 32'h0000_2000,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_i,
    input  logic [NUM_REQ*32-1:0]   addr_i,
    input  logic [NUM_REQ-1:0]      we_i,
    input  logic [NUM_REQ*4-1:0]    be_i,
    input  logic [NUM_REQ*32-1:0]   wdata_i,
    output logic [NUM_REQ-1:0]      gnt_o,
    output logic [NUM_REQ-1:0]      rvalid_o,
    output logic [NUM_REQ-1:0]      err_o,
    output logic [31:0]             rdata_o,
    output logic                    mem_req_o,
    output logic [31:0]             mem_addr_o,
    output logic                    mem_we_o,
    output logic [3:0]              mem_be_o,
    output logic [31:0]             mem_wdata_o,
    input  logic                    mem_rvalid_i,
    input  logic                    mem_err_i,
    input  logic [31:0]             mem_rdata_i,
    output logic                    busy_o,
    output logic                    stray_o
);

    localparam int            PW       = $clog2(NUM_REQ);
    localparam int            TW       = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam bit            TMO_EN   = (TIMEOUT_CYC != 0);

    arb_state_e    state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] owner_q, owner_d;
    mem_req_t      fld_q, fld_d;
    logic          mem_req_q, mem_req_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          stray_q, stray_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [PW-1:0]      arb_idx;
    logic               arb_vld;
    mem_req_t           req_sel;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .vld_o (arb_vld)
    );

    // The offset is applied at latch time so mem_addr_o comes straight from a flop.
    always_comb begin
        req_sel       = '0;
        req_sel.addr  = addr_i[arb_idx*32 +: 32] + ADDR_OFFSET;
        req_sel.we    = we_i[arb_idx];
        req_sel.be    = be_i[arb_idx*4 +: 4];
        req_sel.wdata = wdata_i[arb_idx*32 +: 32];
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        fld_d     = fld_q;
        mem_req_d = 1'b0;
        timer_d   = timer_q;
        stray_d   = stray_q;
        gnt_o     = '0;
        rvalid_o  = '0;
        err_o     = '0;
        rdata_o   = '0;

        case (state_q)
            ARB_IDLE: begin
                if (mem_rvalid_i) stray_d = 1'b1;
                if (arb_vld) begin
                    gnt_o     = arb_gnt;
                    fld_d     = req_sel;
                    owner_d   = arb_idx;
                    ptr_d     = arb_idx;
                    mem_req_d = 1'b1;
                    state_d   = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (mem_rvalid_i) stray_d = 1'b1;
                timer_d = '0;
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (mem_rvalid_i) begin
                    rvalid_o[owner_q] = 1'b1;
                    err_o[owner_q]    = mem_err_i;
                    rdata_o           = mem_rdata_i;
                    state_d           = ARB_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                    if (TMO_EN && timer_q == TMO_LAST) begin
                        rvalid_o[owner_q] = 1'b1;
                        err_o[owner_q]    = 1'b1;
                        timer_d           = '0;
                        state_d           = ARB_DRAIN;
                    end
                end
            end
            ARB_DRAIN: begin
                // Swallow the late response of the timed-out access before reusing the port.
                if (mem_rvalid_i) begin
                    state_d = ARB_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                    if (timer_q == TMO_LAST) state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        // A reset cycle abandons the transaction: nothing is granted or answered.
        if (rst) begin
            gnt_o    = '0;
            rvalid_o = '0;
            err_o    = '0;
            rdata_o  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            ptr_q     <= PW'(NUM_REQ - 1);
            owner_q   <= '0;
            fld_q     <= '0;
            mem_req_q <= 1'b0;
            timer_q   <= '0;
            stray_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            fld_q     <= fld_d;
            mem_req_q <= mem_req_d;
            timer_q   <= timer_d;
            stray_q   <= stray_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = fld_q.addr;
    assign mem_we_o    = fld_q.we;
    assign mem_be_o    = fld_q.be;
    assign mem_wdata_o = fld_q.wdata;
    assign busy_o      = (state_q != ARB_IDLE);
    assign stray_o     = stray_q;

endmodule
